observe_trigger: RTL



---
 rtl/observe_trigger.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/observe_trigger.sv
// observe_trigger: two-stage masked sequence trigger over a registered observe bus.
// Patterns and window come from a bit-serial configuration chain that is only
// writable while the trigger is idle. A decision taken at an edge shows up as a
// one-cycle trig_o pulse after that edge.

// Masked equality compare for one trigger stage.
module observe_trigger_stage #(
   parameter int N_OBS = 8
) (
   input  logic [N_OBS-1:0] obs_i,
   input  logic [N_OBS-1:0] val_i,
   input  logic [N_OBS-1:0] mask_i,
   output logic             match_o
);
   // Mask bit 1 = compared; an all-zero mask matches anything.
   assign match_o = (((obs_i ^ val_i) & mask_i) == '0);
endmodule

module observe_trigger #(
   parameter int N_OBS = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_OBS-1:0] obs_in,
   input  logic             arm,
   input  logic             cfg_we,
   input  logic             cfg_bit,
   input  logic             hit_clr,
   output logic             trig_o,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [1:0]       state_o
);
   localparam int L = 4*N_OBS + CNT_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ARMED = 2'b01,
      S_SEQ   = 2'b10
   } state_t;

   // Field view of the chain; first bit shifted in ends up in s0_val[0].
   typedef struct packed {
      logic [CNT_W-1:0] win;
      logic [N_OBS-1:0] s1_mask;
      logic [N_OBS-1:0] s1_val;
      logic [N_OBS-1:0] s0_mask;
      logic [N_OBS-1:0] s0_val;
   } cfg_t;

   state_t           state_q, state_d;
   logic [L-1:0]     cfg_q, cfg_d;
   logic [N_OBS-1:0] obs_q;
   logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0] hit_q, hit_d;
   logic             trig_q, trig_d;
   cfg_t             cfg;

   logic [1:0][N_OBS-1:0] stage_val, stage_mask;
   logic [1:0]            stage_match;
   logic                  m0, m1;

   assign cfg        = cfg_t'(cfg_q);
   assign stage_val  = {cfg.s1_val,  cfg.s0_val};
   assign stage_mask = {cfg.s1_mask, cfg.s0_mask};

   for (genvar g = 0; g < 2; g++) begin : g_stage
      observe_trigger_stage #(.N_OBS(N_OBS)) u_stage (
         .obs_i   (obs_q),
         .val_i   (stage_val[g]),
         .mask_i  (stage_mask[g]),
         .match_o (stage_match[g])
      );
   end

   assign m0 = stage_match[0];
   assign m1 = stage_match[1];

   // Config chain shifts LSB-ward, only while idle so a live trigger never retargets.
   always_comb begin
      cfg_d = cfg_q;
      if (state_q == S_IDLE && cfg_we) cfg_d = {cfg_bit, cfg_q[L-1:1]};
   end

   // Sequence FSM: stage-0 hit opens a window of win samples for stage 1.
   always_comb begin
      state_d   = state_q;
      win_cnt_d = win_cnt_q;
      trig_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (arm) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (!arm) begin
               state_d = S_IDLE;
            end else if (m0) begin
               if (cfg.win == '0) begin
                  trig_d = 1'b1;
               end else begin
                  state_d   = S_SEQ;
                  win_cnt_d = cfg.win;
               end
            end
         end
         S_SEQ: begin
            // Stage-0 matches are ignored here; the window never restarts.
            if (!arm) begin
               state_d = S_IDLE;
            end else if (m1) begin
               trig_d  = 1'b1;
               state_d = S_ARMED;
            end else if (win_cnt_q == CNT_W'(1)) begin
               state_d = S_ARMED;
            end else begin
               win_cnt_d = win_cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Saturating hit counter; clear wins over a same-cycle trigger.
   always_comb begin
      hit_d = hit_q;
      if (hit_clr)                      hit_d = '0;
      else if (trig_d && hit_q != '1)   hit_d = hit_q + CNT_W'(1);
   end

   // State, config and observe registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cfg_q     <= '0;
         obs_q     <= '0;
         win_cnt_q <= '0;
         hit_q     <= '0;
         trig_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         obs_q     <= obs_in;
         win_cnt_q <= win_cnt_d;
         hit_q     <= hit_d;
         trig_q    <= trig_d;
      end
   end

   assign trig_o  = trig_q;
   assign hit_cnt = hit_q;
   assign state_o = state_q;
endmodule
